idu_stage: RTL and testbench

//  RV64I decode stage, directly downstream of the fetch stage. Consumes the IF/ID pipeline register
//  (pc, instr, snxt_pc, execute_en) and reads the integrated 32x64 register file (bypassed from WB).

---
 rtl/idu_stage.sv | 223 ++++++++++++++++++++++
 tb/tb_idu_stage.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/idu_stage.sv
// RV64I decode stage: IF/ID -> ID/EX register, integrated 32x64 regfile with WB bypass,
// immediate generation, control decode and load-use hazard detection.
module idu_stage #(
    parameter logic [63:0] RESET_PC  = 64'h0,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic [63:0] ifu_pc,
    input  logic [31:0] ifu_instr,
    input  logic [63:0] ifu_snxt_pc,
    input  logic        ifu_execute_en,
    input  logic        flush_nop,
    input  logic        ex_mem_read,
    input  logic [4:0]  ex_rd,
    input  logic        wb_wen,
    input  logic [4:0]  wb_rd,
    input  logic [63:0] wb_data,
    output logic        ld_hz_stop,
    output logic [63:0] idu_pc,
    output logic [63:0] idu_snxt_pc,
    output logic [31:0] idu_instr,
    output logic [63:0] idu_rs1_data,
    output logic [63:0] idu_rs2_data,
    output logic [63:0] idu_imm,
    output logic [4:0]  idu_rs1,
    output logic [4:0]  idu_rs2,
    output logic [4:0]  idu_rd,
    output logic        idu_wen,
    output logic        idu_mem_read,
    output logic        idu_mem_write,
    output logic        idu_illegal,
    output logic        idu_execute_en
);

    localparam int unsigned XLEN = 64;
    localparam int unsigned RW   = 5;
    localparam int unsigned NREG = 32;

    localparam logic [6:0] OP_LOAD   = 7'h03;
    localparam logic [6:0] OP_IMM    = 7'h13;
    localparam logic [6:0] OP_AUIPC  = 7'h17;
    localparam logic [6:0] OP_IMM32  = 7'h1B;
    localparam logic [6:0] OP_STORE  = 7'h23;
    localparam logic [6:0] OP_OP     = 7'h33;
    localparam logic [6:0] OP_LUI    = 7'h37;
    localparam logic [6:0] OP_OP32   = 7'h3B;
    localparam logic [6:0] OP_BRANCH = 7'h63;
    localparam logic [6:0] OP_JALR   = 7'h67;
    localparam logic [6:0] OP_JAL    = 7'h6F;
    localparam logic [6:0] OP_SYSTEM = 7'h73;

    logic [XLEN-1:0] rf_q [NREG];
    logic [XLEN-1:0] rf_d [NREG];

    logic [XLEN-1:0] pc_q, pc_d, snxt_q, snxt_d;
    logic [31:0]     instr_q, instr_d;
    logic [XLEN-1:0] rs1_data_q, rs1_data_d, rs2_data_q, rs2_data_d;
    logic [XLEN-1:0] imm_q, imm_d;
    logic [RW-1:0]   rs1_q, rs1_d, rs2_q, rs2_d, rd_q, rd_d;
    logic            wen_q, wen_d, mem_read_q, mem_read_d, mem_write_q, mem_write_d;
    logic            illegal_q, illegal_d, execute_en_q, execute_en_d;

    logic [6:0]      opcode;
    logic [RW-1:0]   dec_rs1, dec_rs2, dec_rd;
    logic [XLEN-1:0] dec_imm, rs1_val, rs2_val;
    logic            legal, uses_rs1, uses_rs2, is_load, is_store, no_wb;

    assign opcode  = ifu_instr[6:0];
    assign dec_rs1 = ifu_instr[19:15];
    assign dec_rs2 = ifu_instr[24:20];
    assign dec_rd  = ifu_instr[11:7];

    // Regfile write port; x0 is never written
    always_comb begin
        rf_d = rf_q;
        if (wb_wen && (wb_rd != 5'd0)) begin
            rf_d[wb_rd] = wb_data;
        end
    end

    // Operand read with same-cycle WB bypass
    always_comb begin
        rs1_val = rf_q[dec_rs1];
        rs2_val = rf_q[dec_rs2];
        if (wb_wen && (wb_rd == dec_rs1)) rs1_val = wb_data;
        if (wb_wen && (wb_rd == dec_rs2)) rs2_val = wb_data;
        if (dec_rs1 == 5'd0) rs1_val = '0;
        if (dec_rs2 == 5'd0) rs2_val = '0;
    end

    // Opcode classification and immediate generation
    always_comb begin
        legal    = 1'b1;
        uses_rs1 = 1'b1;
        uses_rs2 = 1'b0;
        is_load  = 1'b0;
        is_store = 1'b0;
        no_wb    = 1'b0;
        dec_imm  = '0;
        case (opcode)
            OP_LOAD: begin
                is_load = 1'b1;
                dec_imm = {{52{ifu_instr[31]}}, ifu_instr[31:20]};
            end
            OP_IMM, OP_IMM32, OP_JALR: dec_imm = {{52{ifu_instr[31]}}, ifu_instr[31:20]};
            OP_STORE: begin
                is_store = 1'b1;
                uses_rs2 = 1'b1;
                no_wb    = 1'b1;
                dec_imm  = {{52{ifu_instr[31]}}, ifu_instr[31:25], ifu_instr[11:7]};
            end
            OP_BRANCH: begin
                uses_rs2 = 1'b1;
                no_wb    = 1'b1;
                dec_imm  = {{51{ifu_instr[31]}}, ifu_instr[31], ifu_instr[7],
                            ifu_instr[30:25], ifu_instr[11:8], 1'b0};
            end
            OP_LUI, OP_AUIPC: begin
                uses_rs1 = 1'b0;
                dec_imm  = {{32{ifu_instr[31]}}, ifu_instr[31:12], 12'h000};
            end
            OP_JAL: begin
                uses_rs1 = 1'b0;
                dec_imm  = {{43{ifu_instr[31]}}, ifu_instr[31], ifu_instr[19:12],
                            ifu_instr[20], ifu_instr[30:21], 1'b0};
            end
            OP_OP, OP_OP32: uses_rs2 = 1'b1;
            OP_SYSTEM: legal = 1'b1;
            default: legal = 1'b0;
        endcase
    end

    // Load-use hazard; a concurrent flush wins so the redirect is not held off
    always_comb begin
        ld_hz_stop = ifu_execute_en && !flush_nop && ex_mem_read && (ex_rd != 5'd0) &&
                     ((uses_rs1 && (dec_rs1 == ex_rd)) || (uses_rs2 && (dec_rs2 == ex_rd)));
    end

    // ID/EX next state: bubble on flush or stall, else capture decode
    always_comb begin
        pc_d         = ifu_pc;
        snxt_d       = ifu_snxt_pc;
        execute_en_d = ifu_execute_en;
        instr_d      = ifu_instr;
        rs1_data_d   = rs1_val;
        rs2_data_d   = rs2_val;
        imm_d        = dec_imm;
        rs1_d        = dec_rs1;
        rs2_d        = dec_rs2;
        rd_d         = dec_rd;
        wen_d        = ifu_execute_en && legal && !no_wb && (dec_rd != 5'd0);
        mem_read_d   = ifu_execute_en && legal && is_load;
        mem_write_d  = ifu_execute_en && legal && is_store;
        illegal_d    = ifu_execute_en && !legal;
        if (flush_nop || ld_hz_stop) begin
            execute_en_d = 1'b0;
            instr_d      = NOP_INSTR;
            rs1_data_d   = '0;
            rs2_data_d   = '0;
            imm_d        = '0;
            rs1_d        = '0;
            rs2_d        = '0;
            rd_d         = '0;
            wen_d        = 1'b0;
            mem_read_d   = 1'b0;
            mem_write_d  = 1'b0;
            illegal_d    = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            for (int unsigned i = 0; i < NREG; i++) rf_q[i] <= '0;
            pc_q         <= RESET_PC;
            snxt_q       <= RESET_PC;
            instr_q      <= NOP_INSTR;
            rs1_data_q   <= '0;
            rs2_data_q   <= '0;
            imm_q        <= '0;
            rs1_q        <= '0;
            rs2_q        <= '0;
            rd_q         <= '0;
            wen_q        <= 1'b0;
            mem_read_q   <= 1'b0;
            mem_write_q  <= 1'b0;
            illegal_q    <= 1'b0;
            execute_en_q <= 1'b0;
        end else begin
            rf_q         <= rf_d;
            pc_q         <= pc_d;
            snxt_q       <= snxt_d;
            instr_q      <= instr_d;
            rs1_data_q   <= rs1_data_d;
            rs2_data_q   <= rs2_data_d;
            imm_q        <= imm_d;
            rs1_q        <= rs1_d;
            rs2_q        <= rs2_d;
            rd_q         <= rd_d;
            wen_q        <= wen_d;
            mem_read_q   <= mem_read_d;
            mem_write_q  <= mem_write_d;
            illegal_q    <= illegal_d;
            execute_en_q <= execute_en_d;
        end
    end

    assign idu_pc         = pc_q;
    assign idu_snxt_pc    = snxt_q;
    assign idu_instr      = instr_q;
    assign idu_rs1_data   = rs1_data_q;
    assign idu_rs2_data   = rs2_data_q;
    assign idu_imm        = imm_q;
    assign idu_rs1        = rs1_q;
    assign idu_rs2        = rs2_q;
    assign idu_rd         = rd_q;
    assign idu_wen        = wen_q;
    assign idu_mem_read   = mem_read_q;
    assign idu_mem_write  = mem_write_q;
    assign idu_illegal    = illegal_q;
    assign idu_execute_en = execute_en_q;

endmodule

// File: tb/tb_idu_stage.sv
// Self-checking bench for idu_stage: expected ID/EX contents queued at drive time, compared one cycle later.
module tb_idu_stage;

    logic        clk;
    logic        rstn;
    logic [63:0] ifu_pc, ifu_snxt_pc, wb_data;
    logic [31:0] ifu_instr;
    logic        ifu_execute_en, flush_nop, ex_mem_read, wb_wen;
    logic [4:0]  ex_rd, wb_rd;
    logic        ld_hz_stop;
    logic [63:0] idu_pc, idu_snxt_pc, idu_rs1_data, idu_rs2_data, idu_imm;
    logic [31:0] idu_instr;
    logic [4:0]  idu_rs1, idu_rs2, idu_rd;
    logic        idu_wen, idu_mem_read, idu_mem_write, idu_illegal, idu_execute_en;

    idu_stage dut (
        .clk(clk), .rstn(rstn),
        .ifu_pc(ifu_pc), .ifu_instr(ifu_instr), .ifu_snxt_pc(ifu_snxt_pc),
        .ifu_execute_en(ifu_execute_en), .flush_nop(flush_nop),
        .ex_mem_read(ex_mem_read), .ex_rd(ex_rd),
        .wb_wen(wb_wen), .wb_rd(wb_rd), .wb_data(wb_data),
        .ld_hz_stop(ld_hz_stop),
        .idu_pc(idu_pc), .idu_snxt_pc(idu_snxt_pc), .idu_instr(idu_instr),
        .idu_rs1_data(idu_rs1_data), .idu_rs2_data(idu_rs2_data), .idu_imm(idu_imm),
        .idu_rs1(idu_rs1), .idu_rs2(idu_rs2), .idu_rd(idu_rd),
        .idu_wen(idu_wen), .idu_mem_read(idu_mem_read), .idu_mem_write(idu_mem_write),
        .idu_illegal(idu_illegal), .idu_execute_en(idu_execute_en)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        bub;
        logic        en;
        logic [31:0] instr;
        logic [63:0] pc, snxt, rs1d, rs2d, imm;
        logic [4:0]  rs1, rs2, rd;
        logic        wen, mr, mw, ill;
    } exp_t;

    exp_t        sb[$];
    int          total = 0;
    int          bad   = 0;
    logic [63:0] pc_cur = 64'h1000;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic exp_t mk(input logic en, input logic [31:0] instr,
                                input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                                input logic [63:0] rs1d, input logic [63:0] rs2d, input logic [63:0] imm,
                                input logic wen, input logic mr, input logic mw, input logic ill);
        exp_t e;
        e.bub = 1'b0; e.en = en; e.instr = instr;
        e.pc = '0; e.snxt = '0;
        e.rs1 = rs1; e.rs2 = rs2; e.rd = rd;
        e.rs1d = rs1d; e.rs2d = rs2d; e.imm = imm;
        e.wen = wen; e.mr = mr; e.mw = mw; e.ill = ill;
        return e;
    endfunction

    function automatic exp_t bub();
        exp_t e;
        e = mk(1'b0, 32'h13, 5'd0, 5'd0, 5'd0, '0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
        e.bub = 1'b1;
        return e;
    endfunction

    // One decode cycle: drive IF/ID and side inputs, check hazard, then compare ID/EX
    task automatic step(input logic [31:0] instr, input logic en, input logic fl,
                        input logic exr, input logic [4:0] exrd,
                        input logic ww, input logic [4:0] wrd, input logic [63:0] wd,
                        input logic hz_exp, input exp_t e_in);
        exp_t e, o;
        @(negedge clk);
        ifu_instr = instr; ifu_execute_en = en; flush_nop = fl;
        ifu_pc = pc_cur; ifu_snxt_pc = pc_cur + 64'd4;
        ex_mem_read = exr; ex_rd = exrd;
        wb_wen = ww; wb_rd = wrd; wb_data = wd;
        #1;
        check("ld_hz_stop", 64'(ld_hz_stop), 64'(hz_exp));
        e = e_in;
        e.pc = pc_cur; e.snxt = pc_cur + 64'd4;
        sb.push_back(e);
        pc_cur = pc_cur + 64'd4;
        @(posedge clk);
        #1;
        o = sb.pop_front();
        check("execute_en", 64'(idu_execute_en), 64'(o.en));
        check("instr", 64'(idu_instr), 64'(o.instr));
        check("pc", idu_pc, o.pc);
        check("snxt_pc", idu_snxt_pc, o.snxt);
        check("wen", 64'(idu_wen), 64'(o.wen));
        check("mem_read", 64'(idu_mem_read), 64'(o.mr));
        check("mem_write", 64'(idu_mem_write), 64'(o.mw));
        check("illegal", 64'(idu_illegal), 64'(o.ill));
        if (!o.bub) begin
            check("rs1", 64'(idu_rs1), 64'(o.rs1));
            check("rs2", 64'(idu_rs2), 64'(o.rs2));
            check("rd", 64'(idu_rd), 64'(o.rd));
            check("rs1_data", idu_rs1_data, o.rs1d);
            check("rs2_data", idu_rs2_data, o.rs2d);
            check("imm", idu_imm, o.imm);
        end
    endtask

    initial begin
        logic [31:0] ri;
        // Reset held 2 cycles while a WB write and a valid instruction are presented
        rstn = 1'b0;
        ifu_instr = 32'h006283B3; ifu_execute_en = 1'b1; flush_nop = 1'b0;
        ifu_pc = 64'hDEAD; ifu_snxt_pc = 64'hDEB1;
        ex_mem_read = 1'b0; ex_rd = 5'd0;
        wb_wen = 1'b1; wb_rd = 5'd5; wb_data = 64'hBAD;
        repeat (2) @(posedge clk);
        #1;
        check("rst_execute_en", 64'(idu_execute_en), 64'd0);
        check("rst_instr", 64'(idu_instr), 64'h13);
        check("rst_pc", idu_pc, 64'h0);
        check("rst_snxt_pc", idu_snxt_pc, 64'h0);
        check("rst_wen", 64'(idu_wen), 64'd0);
        check("rst_imm", idu_imm, 64'd0);
        @(negedge clk);
        rstn = 1'b1; wb_wen = 1'b0;

        // All registers read zero after reset
        for (int i = 1; i < 32; i++) begin
            ri = {7'd0, 5'(i), 5'(i), 3'd0, 5'd0, 7'h33};
            step(ri, 1'b1, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 64'd0, 1'b0,
                 mk(1'b1, ri, 5'(i), 5'(i), 5'd0, 64'd0, 64'd0, 64'd0, 1'b0, 1'b0, 1'b0, 1'b0));
        end

        // WB x5=0x1234 under an invalid slot, then addi x6,x5,-1
        step(32'h13, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1, 5'd5, 64'h1234, 1'b0,
             mk(1'b0, 32'h13, 5'd0, 5'd0, 5'd0, 64'd0, 64'd0, 64'd0, 1'b0, 1'b0, 1'b0, 1'b0));
        step(32'hFFF28313, 1'b1, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 64'd0, 1'b0,
             mk(1'b1, 32'hFFF28313, 5'd5, 5'd31, 5'd6, 64'h1234, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF,
                1'b1, 1'b0, 1'b0, 1'b0));

        // Load-use on rs1 and rs2 -> bubble; ex_rd=0 and cleared load -> issue
        step(32'h006283B3, 1'b1, 1'b0, 1'b1, 5'd5, 1'b0, 5'd0, 64'd0, 1'b1, bub());
        step(32'h006283B3, 1'b1, 1'b0, 1'b1, 5'd6, 1'b0, 5'd0, 64'd0, 1'b1, bub());
        step(32'h006283B3, 1'b1, 1'b0, 1'b1, 5'd0, 1'b0, 5'd0, 64'd0, 1'b0,
             mk(1'b1, 32'h006283B3, 5'd5, 5'd6, 5'd7, 64'h1234, 64'd0, 64'd0, 1'b1, 1'b0, 1'b0, 1'b0));
        step(32'h006283B3, 1'b1, 1'b0, 1'b0, 5'd5, 1'b0, 5'd0, 64'd0, 1'b0,
             mk(1'b1, 32'h006283B3, 5'd5, 5'd6, 5'd7, 64'h1234, 64'd0, 64'd0, 1'b1, 1'b0, 1'b0, 1'b0));

        // lui x5: rs1 field matches ex_rd but is unused
        step(32'h123452B7, 1'b1, 1'b0, 1'b1, 5'd8, 1'b0, 5'd0, 64'd0, 1'b0,
             mk(1'b1, 32'h123452B7, 5'd8, 5'd3, 5'd5, 64'd0, 64'd0, 64'h12345000,
                1'b1, 1'b0, 1'b0, 1'b0));

        // sd x3,8(x2) with same-cycle WB of x3, then x3 committed
        step(32'h00313423, 1'b1, 1'b0, 1'b0, 5'd0, 1'b1, 5'd3, 64'hAA, 1'b0,
             mk(1'b1, 32'h00313423, 5'd2, 5'd3, 5'd8, 64'd0, 64'hAA, 64'd8, 1'b0, 1'b0, 1'b1, 1'b0));
        step(32'h005184B3, 1'b1, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 64'd0, 1'b0,
             mk(1'b1, 32'h005184B3, 5'd3, 5'd5, 5'd9, 64'hAA, 64'h1234, 64'd0, 1'b1, 1'b0, 1'b0, 1'b0));

        // ld x10,16(x5) valid, then invalid with matching load in EX
        step(32'h0102B503, 1'b1, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 64'd0, 1'b0,
             mk(1'b1, 32'h0102B503, 5'd5, 5'd16, 5'd10, 64'h1234, 64'd0, 64'd16, 1'b1, 1'b1, 1'b0, 1'b0));
        step(32'h0102B503, 1'b0, 1'b0, 1'b1, 5'd5, 1'b0, 5'd0, 64'd0, 1'b0,
             mk(1'b0, 32'h0102B503, 5'd5, 5'd16, 5'd10, 64'h1234, 64'd0, 64'd16, 1'b0, 1'b0, 1'b0, 1'b0));

        // Flush masks the stall; writes to x0 are discarded and not bypassed
        step(32'h006283B3, 1'b1, 1'b1, 1'b1, 5'd5, 1'b1, 5'd0, 64'hDEAD, 1'b0, bub());
        step(32'h000005B3, 1'b1, 1'b0, 1'b0, 5'd0, 1'b1, 5'd0, 64'hDEAD, 1'b0,
             mk(1'b1, 32'h000005B3, 5'd0, 5'd0, 5'd11, 64'd0, 64'd0, 64'd0, 1'b1, 1'b0, 1'b0, 1'b0));

        // Illegal opcode with nonzero rd, jal x1,-4, beq x0,x0,+16
        step(32'h0000057F, 1'b1, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 64'd0, 1'b0,
             mk(1'b1, 32'h0000057F, 5'd0, 5'd0, 5'd10, 64'd0, 64'd0, 64'd0, 1'b0, 1'b0, 1'b0, 1'b1));
        step(32'hFFDFF0EF, 1'b1, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 64'd0, 1'b0,
             mk(1'b1, 32'hFFDFF0EF, 5'd31, 5'd29, 5'd1, 64'd0, 64'd0, 64'hFFFF_FFFF_FFFF_FFFC,
                1'b1, 1'b0, 1'b0, 1'b0));
        step(32'h00000863, 1'b1, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 64'd0, 1'b0,
             mk(1'b1, 32'h00000863, 5'd0, 5'd0, 5'd16, 64'd0, 64'd0, 64'd16, 1'b0, 1'b0, 1'b0, 1'b0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
